gen_burst_scheduler: RTL and testbench

Sequencing controller for the 32-bit counting data generator in the master FIFO test path. It converts a software-style start command plus burst configuration into the generator's per-cycle `gen` strobe. It emits a programmed number of bursts of programmed length, separated by idle gaps. It throttles on the downstream FIFO almost-full flag so no generated word is lost.

---
 rtl/gen_sched_pkg.sv | 13 +
 rtl/sched_cnt.sv | 32 +++
 rtl/gen_burst_scheduler.sv | 115 +++++++++++
 tb/tb_gen_burst_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_sched_pkg.sv
// Shared types and defaults for the burst scheduler and its counters.
package gen_sched_pkg;

    localparam int unsigned CW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP,
        DONE
    } sched_state_t;

endpackage

// File: rtl/sched_cnt.sv
// Span counter with synchronous clear and enable; tc flags the last count of a
// programmed span of `match` cycles.
module sched_cnt
    import gen_sched_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] match,
    output logic          tc
);

    logic [CW-1:0] count;

    // Clear has priority so a terminal cycle restarts the span in one step.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // Terminal match: the current count is the last one of the span.
    always_comb begin
        tc = (count == match - CW'(1));
    end

endmodule

// File: rtl/gen_burst_scheduler.sv
// Burst scheduler: turns a start command plus burst configuration into the
// data generator's gen strobe, with inter-burst gaps and FIFO back-pressure.
module gen_burst_scheduler
    import gen_sched_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] cfg_burst_len,
    input  logic [CW-1:0] cfg_gap,
    input  logic [CW-1:0] cfg_num_bursts,
    input  logic          fifo_afull,
    output logic          gen,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] burst_cnt
);

    sched_state_t  state;
    logic [CW-1:0] len_q;
    logic [CW-1:0] gap_q;
    logic [CW-1:0] num_q;
    logic [CW-1:0] burst_next;
    logic          beat_tc;
    logic          gap_tc;
    logic          last_beat;
    logic          beat_clr;
    logic          gap_en;
    logic          gap_clr;

    // Strobe and counter controls; counters are held at zero outside their state.
    always_comb begin
        gen        = (state == BURST) && !fifo_afull && !stop;
        last_beat  = gen && beat_tc;
        beat_clr   = (state != BURST) || last_beat;
        gap_en     = (state == GAP);
        gap_clr    = (state != GAP) || gap_tc;
        burst_next = burst_cnt + CW'(1);
    end

    sched_cnt #(.CW(CW)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (beat_clr),
        .en    (gen),
        .match (len_q),
        .tc    (beat_tc)
    );

    sched_cnt #(.CW(CW)) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (gap_clr),
        .en    (gap_en),
        .match (gap_q),
        .tc    (gap_tc)
    );

    // Run sequencing, config latches, burst count and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            num_q     <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && (cfg_burst_len != '0)) begin
                        len_q     <= cfg_burst_len;
                        gap_q     <= cfg_gap;
                        num_q     <= cfg_num_bursts;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last_beat) begin
                        burst_cnt <= burst_next;
                        if ((num_q != '0) && (burst_next == num_q)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (gap_q != '0) begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (gap_tc) begin
                        state <= BURST;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_burst_scheduler.sv
// Self-checking bench for gen_burst_scheduler. The reference model expands a
// run into a queue of slots (beat / last beat / gap) and consumes it cycle by cycle.
module tb_gen_burst_scheduler;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] cfg_burst_len;
    logic [CW-1:0] cfg_gap;
    logic [CW-1:0] cfg_num_bursts;
    logic          fifo_afull;
    logic          gen;
    logic          busy;
    logic          done;
    logic [CW-1:0] burst_cnt;

    always #5 clk = ~clk;

    gen_burst_scheduler #(.CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_gap        (cfg_gap),
        .cfg_num_bursts (cfg_num_bursts),
        .fifo_afull     (fifo_afull),
        .gen            (gen),
        .busy           (busy),
        .done           (done),
        .burst_cnt      (burst_cnt)
    );

    // Reference model: slots 1 = beat, 2 = last beat of a burst, 0 = gap cycle.
    int            q[$];
    bit            m_inf;
    int            m_len;
    int            m_gap;
    logic [CW-1:0] m_bcnt;
    bit            m_done;
    logic          e_gen;
    logic          e_busy;
    logic          e_done;
    logic [CW-1:0] e_bcnt;
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic void push_burst(int len);
        for (int i = 0; i < len; i++) q.push_back((i == len - 1) ? 2 : 1);
    endfunction

    function automatic void push_gap(int g);
        for (int i = 0; i < g; i++) q.push_back(0);
    endfunction

    function automatic void model_eval();
        e_busy = (q.size() != 0);
        e_done = m_done;
        e_bcnt = m_bcnt;
        e_gen  = (q.size() != 0) ? ((q[0] != 0) && !fifo_afull && !stop) : 1'b0;
    endfunction

    function automatic void model_update();
        bit was_done;
        int item;
        was_done = m_done;
        m_done   = 1'b0;
        if (rst) begin
            q.delete();
            m_bcnt = '0;
            m_inf  = 1'b0;
            m_len  = 0;
            m_gap  = 0;
        end else if (q.size() != 0) begin
            if (stop) begin
                q.delete();
            end else if (q[0] == 0) begin
                void'(q.pop_front());
            end else if (!fifo_afull) begin
                item = q.pop_front();
                if (item == 2) begin
                    m_bcnt = m_bcnt + CW'(1);
                    if (m_inf) begin
                        push_gap(m_gap);
                        push_burst(m_len);
                    end else if (q.size() == 0) begin
                        m_done = 1'b1;
                    end
                end
            end
        end else if (!was_done && start && !stop && (cfg_burst_len != '0)) begin
            m_inf  = (cfg_num_bursts == '0);
            m_len  = int'(cfg_burst_len);
            m_gap  = int'(cfg_gap);
            m_bcnt = '0;
            if (m_inf) begin
                push_burst(m_len);
            end else begin
                for (int b = 0; b < int'(cfg_num_bursts); b++) begin
                    if (b != 0) push_gap(m_gap);
                    push_burst(m_len);
                end
            end
        end
    endfunction

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int len, input int gap, input int num);
        cfg_burst_len  = CW'(len);
        cfg_gap        = CW'(gap);
        cfg_num_bursts = CW'(num);
        start = 1'b1;
        sample();
        advance();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; fifo_afull = 1'b0;
        cfg_burst_len = '0; cfg_gap = '0; cfg_num_bursts = '0;
        m_done = 1'b0;
        advance();
        advance();
        sample();
        n_checks++;
        if ({gen, busy, done, burst_cnt} !== {3'b000, {CW{1'b0}}})
            $display("FAIL reset got %b/%b/%b/%0d exp 0/0/0/0", gen, busy, done, burst_cnt);
        else n_pass++;
        rst = 1'b0;
        advance();
    endtask

    task automatic test_basic();
        logic [15:0] pat;
        int beats, last_beat, done_at;
        pat = '0; beats = 0; last_beat = -1; done_at = -1;
        launch(4, 2, 3);
        for (int c = 0; c < 24; c++) begin
            sample();
            n_checks++;
            if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                $display("FAIL basic c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                         c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
            else n_pass++;
            if (c < 16) pat[15-c] = gen;
            if (gen) begin beats++; last_beat = c; end
            if (done) done_at = c;
            advance();
        end
        n_checks++;
        if (pat !== 16'b1111_0011_1100_1111) $display("FAIL basic_pattern got %b exp 1111001111001111", pat);
        else n_pass++;
        n_checks++;
        if (beats != 12) $display("FAIL basic_beats got %0d exp 12", beats);
        else n_pass++;
        n_checks++;
        if (done_at != 16 || last_beat != 15)
            $display("FAIL basic_done_timing got done@%0d last@%0d exp done@16 last@15", done_at, last_beat);
        else n_pass++;
        n_checks++;
        if (burst_cnt !== 16'd3) $display("FAIL basic_burst_cnt got %0d exp 3", burst_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] pat;
        pat = '0;
        launch(3, 0, 2);
        for (int c = 0; c < 9; c++) begin
            sample();
            n_checks++;
            if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                $display("FAIL b2b c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                         c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
            else n_pass++;
            if (c < 7) pat[6-c] = gen;
            if (c == 3) begin
                n_checks++;
                if (burst_cnt !== 16'd1) $display("FAIL b2b_cnt1 got %0d exp 1", burst_cnt);
                else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if ({done, burst_cnt} !== {1'b1, 16'd2})
                    $display("FAIL b2b_done got done=%b cnt=%0d exp done=1 cnt=2", done, burst_cnt);
                else n_pass++;
            end
            advance();
        end
        n_checks++;
        if (pat !== 7'b1111110) $display("FAIL b2b_pattern got %b exp 1111110", pat);
        else n_pass++;
    endtask

    task automatic test_stall();
        int beats, stall_beats, done_at;
        beats = 0; stall_beats = 0; done_at = -1;
        launch(5, 1, 1);
        for (int c = 0; c < 12; c++) begin
            fifo_afull = (c >= 2 && c <= 4);
            sample();
            n_checks++;
            if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                $display("FAIL stall c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                         c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
            else n_pass++;
            if (gen) beats++;
            if (gen && fifo_afull) stall_beats++;
            if (done) done_at = c;
            advance();
        end
        fifo_afull = 1'b0;
        n_checks++;
        if (stall_beats != 0 || beats != 5)
            $display("FAIL stall_beats got %0d total %0d during afull exp 5 total 0 during afull", beats, stall_beats);
        else n_pass++;
        n_checks++;
        if (done_at != 8) $display("FAIL stall_done got cycle %0d exp 8", done_at);
        else n_pass++;
    endtask

    task automatic test_infinite_stop();
        int dones;
        dones = 0;
        launch(2, 1, 0);
        for (int c = 0; c < 34; c++) begin
            stop = (c == 30);
            sample();
            n_checks++;
            if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                $display("FAIL inf c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                         c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
            else n_pass++;
            if (c == 30) begin
                n_checks++;
                if (gen !== 1'b0) $display("FAIL inf_stop_gen got %b exp 0", gen);
                else n_pass++;
            end
            if (c == 31) begin
                n_checks++;
                if ({gen, busy} !== 2'b00) $display("FAIL inf_idle got gen=%b busy=%b exp 0/0", gen, busy);
                else n_pass++;
            end
            if (done) dones++;
            advance();
        end
        stop = 1'b0;
        n_checks++;
        if (dones != 0 || burst_cnt !== 16'd10)
            $display("FAIL inf_end got dones=%0d cnt=%0d exp dones=0 cnt=10", dones, burst_cnt);
        else n_pass++;
    endtask

    task automatic test_illegal_start();
        int beats;
        launch(0, 1, 1);
        sample();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL len0_busy got %b exp 0", busy);
        else n_pass++;
        advance();
        beats = 0;
        launch(2, 1, 2);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin
                cfg_burst_len = 16'd5; cfg_gap = 16'd0; cfg_num_bursts = 16'd3;
            end
            start = (c == 1);
            sample();
            n_checks++;
            if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                $display("FAIL relaunch c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                         c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
            else n_pass++;
            if (gen) beats++;
            advance();
        end
        start = 1'b0;
        n_checks++;
        if (beats != 4 || burst_cnt !== 16'd2)
            $display("FAIL relaunch_total got beats=%0d cnt=%0d exp beats=4 cnt=2", beats, burst_cnt);
        else n_pass++;
        stop = 1'b1;
        launch(3, 0, 1);
        stop = 1'b0;
        sample();
        n_checks++;
        if ({gen, busy} !== 2'b00) $display("FAIL start_stop got gen=%b busy=%b exp 0/0", gen, busy);
        else n_pass++;
        advance();
    endtask

    task automatic test_rst_gap();
        int beats, dones;
        launch(3, 3, 2);
        for (int c = 0; c < 4; c++) begin
            rst = (c == 3);
            sample();
            n_checks++;
            if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                $display("FAIL rstgap c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                         c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
            else n_pass++;
            advance();
        end
        rst = 1'b0;
        sample();
        n_checks++;
        if ({gen, busy, done, burst_cnt} !== {3'b000, {CW{1'b0}}})
            $display("FAIL rstgap_clear got %b/%b/%b/%0d exp 0/0/0/0", gen, busy, done, burst_cnt);
        else n_pass++;
        advance();
        beats = 0; dones = 0;
        launch(2, 0, 1);
        for (int c = 0; c < 6; c++) begin
            sample();
            if (gen) beats++;
            if (done) dones++;
            advance();
        end
        n_checks++;
        if (beats != 2 || dones != 1)
            $display("FAIL rstgap_rerun got beats=%0d dones=%0d exp beats=2 dones=1", beats, dones);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            for (int c = 0; c < 60; c++) begin
                start          = ($urandom_range(5) == 0);
                stop           = ($urandom_range(49) == 0);
                fifo_afull     = ($urandom_range(9) < 3);
                cfg_burst_len  = CW'($urandom_range(4));
                cfg_gap        = CW'($urandom_range(3));
                cfg_num_bursts = CW'($urandom_range(3));
                sample();
                n_checks++;
                if ({gen, busy, done, burst_cnt} !== {e_gen, e_busy, e_done, e_bcnt})
                    $display("FAIL random i%0d c%0d got %b/%b/%b/%0d exp %b/%b/%b/%0d",
                             it, c, gen, busy, done, burst_cnt, e_gen, e_busy, e_done, e_bcnt);
                else n_pass++;
                advance();
            end
        end
        start = 1'b0; stop = 1'b0; fifo_afull = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_infinite_stop();
        test_illegal_start();
        test_rst_gap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
